dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU pipeline MEM stage and the audio sample DMA streamer that feeds the reverb engine.
- Round-robin arbitration with a fixed-latency access sequencer.
- Drives a stall to the pipeline while the CPU access is pending.
- Sits between the MEM-stage write enable (after condition gating) and the data RAM.

Parameters:
AW, 32, address width
DW, 32, data width
LAT, 2, RAM read latency in cycles (>=1); mem_rdata is valid LAT cycles after the cycle with mem_en=1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request, level; held until cpu_done
cpu_we  in  1  CPU write (1) / read (0)
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_rdata  out  DW  CPU read data, valid when cpu_done=1
cpu_done  out  1  one-cycle completion pulse to CPU
cpu_stall  out  1  pipeline stall = cpu_req & ~cpu_done (combinational)
dma_req  in  1  DMA request, level; held until dma_ack
dma_we  in  1  DMA write/read
dma_addr  in  AW  DMA address
dma_wdata  in  DW  DMA write data
dma_rdata  out  DW  DMA read data, valid when dma_ack=1
dma_ack  out  1  one-cycle completion pulse to DMA
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_addr  out  AW  RAM address
mem_wdata  out  DW  RAM write data
mem_rdata  in  DW  RAM read data

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM to IDLE; last_grant=DMA, so the CPU wins the first tie.
  - Latched we/addr/wdata cleared; wait counter=0.
  - All outputs 0; cpu_stall follows cpu_req.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If any request is present, pick the winner, latch its we/addr/wdata and grant id, update last_grant, then go to ACCESS.
  - If only one requester is active, it wins.
  - If both are active, the one not equal to last_grant wins.
  - With no request, stay in IDLE.
- ACCESS (one cycle):
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latched registers.
  - Write: go to RESP.
  - Read with LAT=1: go to RESP.
  - Read with LAT>1: load counter=LAT-2, go to WAIT.
- WAIT:
  - mem_en=0.
  - Counter==0: go to RESP. Otherwise decrement.
- RESP (one cycle):
  - Assert cpu_done or dma_ack for the granted requester only.
  - Drive the granted requester's rdata = mem_rdata; the other requester's rdata holds its last value.
  - Writes return an unchanged rdata.
  - Next state is always IDLE.
- Latency, counted from the first IDLE cycle with req high to the done pulse:
  - Write: 2 cycles.
  - Read: LAT+1 cycles.
  - The requester sees stall for those cycles and no stall in the done cycle.
- mem_en is 0 in every state except ACCESS. mem_addr, mem_wdata and mem_we hold their latched values outside ACCESS.
- Request inputs are sampled only in IDLE:
  - A request dropped mid-transaction does not abort it; completion still pulses.
  - A request still high in the cycle after done is treated as a new request.
- Fairness: with both requesters continuously active, grants alternate strictly (CPU, DMA, CPU, ...). Neither requester waits more than one foreign transaction.
- A request arriving while the other transaction is in flight waits in stall until the next IDLE.
- Reset mid-transaction:
  - Any pending done/ack is lost; requesters restart.
  - A write whose ACCESS cycle already occurred has been committed to RAM.
- Throughput: at most one transaction per (3 + LAT-1 for reads, 3 for writes) cycles, because RESP→IDLE is mandatory.

Test Plan:
- Reset with LAT=2: rst=0 while cpu_req=1 → mem_en=0, cpu_done=0, dma_ack=0, cpu_stall=1; after release, the first access goes to the CPU.
- CPU read alone: cpu_req=1, cpu_we=0, cpu_addr=0x40, RAM returns 0xDEADBEEF →
  - mem_en=1, addr=0x40 in cycle 1;
  - cpu_done=1, cpu_rdata=0xDEADBEEF in cycle 3;
  - cpu_stall=1 in cycles 0–2 and 0 in cycle 3.
- DMA write alone: dma_we=1, addr=0x100, wdata=0x1234 → mem_en=mem_we=1 with those values in cycle 1; dma_ack in cycle 2; cpu_done never asserted.
- Simultaneous requests after reset, both reads, held continuously → grant order CPU, DMA, CPU, DMA; each mem_en carries the matching address (0x10/0x20).
- Dropped request: DMA read granted, dma_req deasserted in ACCESS → dma_ack still pulses at cycle 3; no second access.
- Reset mid-WAIT: rst=0 during WAIT of a CPU read → no cpu_done; FSM returns to IDLE; the re-issued read completes normally with LAT+1 latency.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one single-port data RAM between the CPU MEM
// stage and the audio DMA streamer, using a fixed-latency access sequence.
module dmem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_done_o,
  output logic          cpu_stall_o,
  input  logic          dma_req_i,
  input  logic          dma_we_i,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [DW-1:0] dma_wdata_i,
  output logic [DW-1:0] dma_rdata_o,
  output logic          dma_ack_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam int            CW         = (LAT > 2) ? $clog2(LAT - 1) : 1;
  localparam logic [CW-1:0] WAIT_INIT  = CW'((LAT >= 2) ? (LAT - 2) : 0);
  localparam logic          SHORT_READ = (LAT == 1);

  // grant encoding: 0 = CPU, 1 = DMA
  state_e        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, cpu_done_q, dma_ack_q;
  logic [DW-1:0] cpu_rdata_q, dma_rdata_q;

  // Next-state logic: arbitration in IDLE, then a fixed access/wait/response walk.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cpu_req_i || dma_req_i) begin
          if (cpu_req_i && dma_req_i) begin
            grant_d = ~last_q;
          end else begin
            grant_d = dma_req_i;
          end
          last_d  = grant_d;
          we_d    = grant_d ? dma_we_i    : cpu_we_i;
          addr_d  = grant_d ? dma_addr_i  : cpu_addr_i;
          wdata_d = grant_d ? dma_wdata_i : cpu_wdata_i;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (we_q || SHORT_READ) begin
          state_d = RESP;
        end else begin
          cnt_d   = WAIT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and registered strobes, decoded from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= {AW{1'b0}};
      wdata_q    <= {DW{1'b0}};
      cnt_q      <= {CW{1'b0}};
      en_q       <= 1'b0;
      cpu_done_q <= 1'b0;
      dma_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      en_q       <= (state_d == ACCESS);
      cpu_done_q <= (state_d == RESP) && !grant_d;
      dma_ack_q  <= (state_d == RESP) && grant_d;
    end
  end

  // Read data captured at response so each requester keeps its last value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cpu_rdata_q <= {DW{1'b0}};
      dma_rdata_q <= {DW{1'b0}};
    end else if (state_q == RESP && !we_q) begin
      if (grant_q) begin
        dma_rdata_q <= mem_rdata_i;
      end else begin
        cpu_rdata_q <= mem_rdata_i;
      end
    end
  end

  assign mem_en_o    = en_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_done_o  = cpu_done_q;
  assign dma_ack_o   = dma_ack_q;
  assign cpu_stall_o = cpu_req_i & ~cpu_done_q;
  // The RAM data is only valid during the response cycle, so bypass the holding register then.
  assign cpu_rdata_o = (cpu_done_q && !we_q) ? mem_rdata_i : cpu_rdata_q;
  assign dma_rdata_o = (dma_ack_q  && !we_q) ? mem_rdata_i : dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level timing and memory model.
module tb_dmem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic          cpu_done, cpu_stall, dma_ack;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int vec = 0;
  int mis = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_done_o(cpu_done), .cpu_stall_o(cpu_stall),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_rdata_o(dma_rdata), .dma_ack_o(dma_ack),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM with LAT-cycle read pipeline; unwritten words return an address-derived pattern
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  logic [31:0]   ram [1024];
  logic [1023:0] wr_valid;
  logic [31:0]   rd_pipe [LAT];
  logic          ram_clr;

  always @(posedge clk) begin
    if (ram_clr) begin
      wr_valid     <= '0;
      wr_valid[16] <= 1'b1;
      ram[16]      <= 32'hDEAD_BEEF;
    end else if (mem_en && mem_we) begin
      ram[mem_addr[11:2]]      <= mem_wdata;
      wr_valid[mem_addr[11:2]] <= 1'b1;
    end
    rd_pipe[0] <= wr_valid[mem_addr[11:2]] ? ram[mem_addr[11:2]] : dflt(mem_addr);
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  task automatic cyc; @(posedge clk); #1; endtask
  task automatic smp; @(negedge clk); endtask

  task automatic idle_inputs;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    cyc;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_addr = 32'h40; dma_req = 1'b1; dma_addr = 32'h20;
    smp;
    vec++; if (mem_en !== 1'b0) begin mis++; $display("FAIL rst_mem_en got %b exp 0", mem_en); end
    vec++; if (cpu_done !== 1'b0) begin mis++; $display("FAIL rst_cpu_done got %b exp 0", cpu_done); end
    vec++; if (dma_ack !== 1'b0) begin mis++; $display("FAIL rst_dma_ack got %b exp 0", dma_ack); end
    vec++; if (cpu_stall !== 1'b1) begin mis++; $display("FAIL rst_stall got %b exp 1", cpu_stall); end
    cyc;
    rst_n = 1'b1;
    cyc; smp;
    vec++; if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin
      mis++; $display("FAIL rst_first_grant got en=%b addr=%h exp en=1 addr=00000040", mem_en, mem_addr);
    end
    cyc;
    cpu_req = 1'b0; dma_req = 1'b0;
    smp;
    cyc; smp;
    vec++; if (cpu_done !== 1'b1 || dma_ack !== 1'b0) begin
      mis++; $display("FAIL rst_first_done got done=%b ack=%b exp 1/0", cpu_done, dma_ack);
    end
    cyc;
  endtask

  task automatic test_cpu_read;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    for (int k = 0; k < 4; k++) begin
      smp;
      vec++; if (cpu_stall !== (k < 3)) begin mis++; $display("FAIL crd_stall c%0d got %b", k, cpu_stall); end
      vec++; if (cpu_done !== (k == 3)) begin mis++; $display("FAIL crd_done c%0d got %b", k, cpu_done); end
      vec++; if (mem_en !== (k == 1)) begin mis++; $display("FAIL crd_en c%0d got %b", k, mem_en); end
      if (k == 1) begin
        vec++; if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin
          mis++; $display("FAIL crd_addr got %h we=%b exp 00000040 we=0", mem_addr, mem_we);
        end
      end
      if (k == 3) begin
        vec++; if (cpu_rdata !== 32'hDEAD_BEEF) begin
          mis++; $display("FAIL crd_rdata got %h exp deadbeef", cpu_rdata);
        end
      end
      cyc;
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_dma_write;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h100; dma_wdata = 32'h1234;
    for (int k = 0; k < 3; k++) begin
      smp;
      vec++; if (cpu_done !== 1'b0) begin mis++; $display("FAIL dwr_cpu_done c%0d got %b", k, cpu_done); end
      vec++; if (dma_ack !== (k == 2)) begin mis++; $display("FAIL dwr_ack c%0d got %b", k, dma_ack); end
      vec++; if (mem_en !== (k == 1)) begin mis++; $display("FAIL dwr_en c%0d got %b", k, mem_en); end
      if (k == 1) begin
        vec++; if (mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'h1234) begin
          mis++; $display("FAIL dwr_bus got we=%b addr=%h wd=%h exp 1/100/1234", mem_we, mem_addr, mem_wdata);
        end
      end
      cyc;
    end
    dma_req = 1'b0; dma_we = 1'b0;
    smp;
    vec++; if (ram[64] !== 32'h1234) begin mis++; $display("FAIL dwr_commit got %h exp 1234", ram[64]); end
    cyc;
  endtask

  task automatic test_fairness;
    logic [31:0] got [4];
    logic [31:0] expv [4];
    int n;
    expv[0] = 32'h10; expv[1] = 32'h20; expv[2] = 32'h10; expv[3] = 32'h20;
    n = 0;
    do_reset;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
    for (int c = 0; c < 40 && n < 4; c++) begin
      smp;
      if (mem_en === 1'b1) begin got[n] = mem_addr; n++; end
      cyc;
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    vec++; if (n != 4) begin mis++; $display("FAIL rr_timeout got %0d grants exp 4", n); end
    for (int i = 0; i < n; i++) begin
      vec++; if (got[i] !== expv[i]) begin mis++; $display("FAIL rr_order%0d got %h exp %h", i, got[i], expv[i]); end
    end
    repeat (6) cyc;
  endtask

  task automatic test_dropped;
    int en_cnt;
    en_cnt = 0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
    for (int k = 0; k < 8; k++) begin
      smp;
      if (mem_en === 1'b1) en_cnt++;
      vec++; if (dma_ack !== (k == 3)) begin mis++; $display("FAIL drop_ack c%0d got %b", k, dma_ack); end
      if (k == 3) begin
        vec++; if (dma_rdata !== dflt(32'h20)) begin
          mis++; $display("FAIL drop_rdata got %h exp %h", dma_rdata, dflt(32'h20));
        end
      end
      cyc;
      if (k == 0) dma_req = 1'b0;
    end
    vec++; if (en_cnt != 1) begin mis++; $display("FAIL drop_accesses got %0d exp 1", en_cnt); end
  endtask

  task automatic test_reset_wait;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    cyc; cyc;
    rst_n = 1'b0;
    smp;
    vec++; if (cpu_done !== 1'b0 || mem_en !== 1'b0 || cpu_stall !== 1'b1) begin
      mis++; $display("FAIL rw_reset got done=%b en=%b stall=%b exp 0/0/1", cpu_done, mem_en, cpu_stall);
    end
    #2 rst_n = 1'b1;
    for (int c = 3; c <= 5; c++) begin
      cyc; smp;
      vec++; if (cpu_done !== (c == 5)) begin mis++; $display("FAIL rw_done c%0d got %b", c, cpu_done); end
      vec++; if (mem_en !== (c == 3)) begin mis++; $display("FAIL rw_en c%0d got %b", c, mem_en); end
      if (c == 5) begin
        vec++; if (cpu_rdata !== 32'hDEAD_BEEF) begin mis++; $display("FAIL rw_rdata got %h exp deadbeef", cpu_rdata); end
      end
    end
    cyc;
    cpu_req = 1'b0;
    cyc;
  endtask

  // Randomized traffic against a transaction-level model: a granted access occupies
  // the RAM for a fixed number of cycles (2 for writes, LAT+1 for reads) plus one idle cycle.
  task automatic test_random;
    logic        a_req [2];
    logic        a_we [2];
    logic [31:0] a_addr [2];
    logic [31:0] a_wd [2];
    logic [31:0] ref_mem [int];
    logic [31:0] e_rd [2];
    logic [1:0]  exp_done, prev_done;
    logic [1:0]  reqs;
    logic        busy, exp_en;
    int          who, t0, len, last;
    logic        m_we;
    logic [31:0] m_addr, m_wd, m_rexp;
    int          k;
    do_reset;
    busy = 1'b0; last = 1; who = 0; t0 = 0; len = 0;
    m_we = 1'b0; m_addr = '0; m_wd = '0; m_rexp = '0;
    e_rd[0] = '0; e_rd[1] = '0;
    prev_done = 2'b00;
    for (int i = 0; i < 2; i++) begin a_req[i] = 1'b0; a_we[i] = 1'b0; a_addr[i] = '0; a_wd[i] = '0; end
    for (int t = 0; t < 520; t++) begin
      for (int i = 0; i < 2; i++) begin
        if (t >= 500) begin
          a_req[i] = 1'b0;
        end else if (!a_req[i] || prev_done[i]) begin
          a_req[i]  = ($urandom_range(0, 99) < 45);
          a_we[i]   = 1'($urandom_range(0, 1));
          a_addr[i] = 32'h800 + 32'($urandom_range(0, 7) << 2);
          a_wd[i]   = $urandom;
        end
      end
      cpu_req = a_req[0]; cpu_we = a_we[0]; cpu_addr = a_addr[0]; cpu_wdata = a_wd[0];
      dma_req = a_req[1]; dma_we = a_we[1]; dma_addr = a_addr[1]; dma_wdata = a_wd[1];
      smp;
      exp_done = 2'b00; exp_en = 1'b0; k = 0;
      reqs = {dma_req, cpu_req};
      if (busy) begin
        k = t - t0;
        exp_en = (k == 1);
        if (k == len) exp_done[who] = 1'b1;
      end else if (reqs != 2'b00) begin
        who    = (reqs == 2'b11) ? (1 - last) : (reqs[1] ? 1 : 0);
        last   = who;
        busy   = 1'b1;
        t0     = t;
        m_we   = a_we[who];
        m_addr = a_addr[who];
        m_wd   = a_wd[who];
        len    = m_we ? 2 : LAT + 1;
        m_rexp = ref_mem.exists(int'(m_addr)) ? ref_mem[int'(m_addr)] : dflt(m_addr);
        if (m_we) ref_mem[int'(m_addr)] = m_wd;
      end
      vec++; if (mem_en !== exp_en) begin mis++; $display("FAIL rnd_en t=%0d got %b exp %b", t, mem_en, exp_en); end
      vec++; if (cpu_done !== exp_done[0]) begin mis++; $display("FAIL rnd_cpu_done t=%0d got %b exp %b", t, cpu_done, exp_done[0]); end
      vec++; if (dma_ack !== exp_done[1]) begin mis++; $display("FAIL rnd_dma_ack t=%0d got %b exp %b", t, dma_ack, exp_done[1]); end
      vec++; if (cpu_stall !== (cpu_req & ~exp_done[0])) begin
        mis++; $display("FAIL rnd_stall t=%0d got %b exp %b", t, cpu_stall, cpu_req & ~exp_done[0]);
      end
      if (exp_en) begin
        vec++; if (mem_we !== m_we || mem_addr !== m_addr || (m_we && mem_wdata !== m_wd)) begin
          mis++; $display("FAIL rnd_bus t=%0d got we=%b addr=%h wd=%h exp we=%b addr=%h wd=%h",
                          t, mem_we, mem_addr, mem_wdata, m_we, m_addr, m_wd);
        end
      end
      if (busy && k == len) begin
        if (!m_we) e_rd[who] = m_rexp;
        vec++; if (cpu_rdata !== e_rd[0] || dma_rdata !== e_rd[1]) begin
          mis++; $display("FAIL rnd_rdata t=%0d got cpu=%h dma=%h exp cpu=%h dma=%h",
                          t, cpu_rdata, dma_rdata, e_rd[0], e_rd[1]);
        end
        busy = 1'b0;
      end
      prev_done = exp_done;
      cyc;
    end
    idle_inputs;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ram_clr = 1'b1;
    rst_n   = 1'b0;
    idle_inputs;
    cyc; cyc;
    ram_clr = 1'b0;
    test_reset;
    test_cpu_read;
    test_dma_write;
    test_fairness;
    test_dropped;
    test_reset_wait;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
